// File: rtl/counter_ctrl.sv
// Command-driven timer sequencer around a WIDTH-bit up-counter.
// Optional prescaler enabled with `define COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 4
) (
   input  logic                  clk_i,
   input  logic                  reset_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [1:0]            cmd_op_i,
   input  logic [WIDTH-1:0]      cmd_data_i,
   input  logic                  periodic_i,
   input  logic                  irq_clr_i,
`ifdef COUNTER_CTRL_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale_i,
`endif
   output logic [WIDTH-1:0]      count_o,
   output logic                  running_o,
   output logic                  match_o,
   output logic                  irq_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_START = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] limit_q, limit_d;
   logic             match_q, match_d;
   logic             irq_q, irq_d;
   logic             accept;
   logic             tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
   logic [PRESCALE_W-1:0] psc_q, psc_d;
   assign tick = (psc_q == prescale_i);
`else
   assign tick = 1'b1;
   if (PRESCALE_W < 1) begin : g_psc_chk
      $error("PRESCALE_W must be positive");
   end
`endif

   assign cmd_ready_o = (state_q != S_DONE);
   assign accept      = cmd_valid_i && cmd_ready_o;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      limit_d = limit_q;
      match_d = 1'b0;
      irq_d   = irq_q && !irq_clr_i;
`ifdef COUNTER_CTRL_PRESCALE_EN
      psc_d   = psc_q;
`endif
      // An accepted command suppresses any tick in the same cycle.
      if (accept) begin
         unique case (cmd_op_i)
            OP_LOAD: limit_d = cmd_data_i;
            OP_START: begin
               count_d = '0;
               state_d = S_RUN;
`ifdef COUNTER_CTRL_PRESCALE_EN
               psc_d   = '0;
`endif
            end
            OP_STOP: state_d = S_IDLE;
            OP_CLEAR: begin
               count_d = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
               psc_d   = '0;
`endif
            end
            default: ;
         endcase
      end else begin
         unique case (state_q)
            S_RUN: begin
`ifdef COUNTER_CTRL_PRESCALE_EN
               psc_d = tick ? '0 : psc_q + PRESCALE_W'(1);
`endif
               if (tick) begin
                  if (count_q != limit_q) begin
                     count_d = count_q + WIDTH'(1);
                  end else begin
                     match_d = 1'b1;
                     irq_d   = 1'b1;
                     if (periodic_i) begin
                        count_d = '0;
                     end else begin
                        state_d = S_DONE;
                     end
                  end
               end
            end
            S_DONE: state_d = S_IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         count_q <= '0;
         limit_q <= '1;
         match_q <= 1'b0;
         irq_q   <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
         psc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         limit_q <= limit_d;
         match_q <= match_d;
         irq_q   <= irq_d;
`ifdef COUNTER_CTRL_PRESCALE_EN
         psc_q   <= psc_d;
`endif
      end
   end

   assign count_o   = count_q;
   assign running_o = (state_q == S_RUN);
   assign match_o   = match_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: expected snapshots and match
// cycles are queued by the stimulus and checked by negedge monitors.
module tb_counter_ctrl;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_START = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       valid = 1'b0;
   logic       ready;
   logic [1:0] op = 2'b00;
   logic [7:0] data = 8'h00;
   logic       periodic = 1'b0;
   logic       irq_clr = 1'b0;
   logic [7:0] count;
   logic       running, match, irq;
`ifdef COUNTER_CTRL_PRESCALE_EN
   logic [3:0] prescale = 4'd0;
`endif

   counter_ctrl #(.WIDTH(8), .PRESCALE_W(4)) dut (
      .clk_i      (clk),
      .reset_ni   (reset_n),
      .cmd_valid_i(valid),
      .cmd_ready_o(ready),
      .cmd_op_i   (op),
      .cmd_data_i (data),
      .periodic_i (periodic),
      .irq_clr_i  (irq_clr),
`ifdef COUNTER_CTRL_PRESCALE_EN
      .prescale_i (prescale),
`endif
      .count_o    (count),
      .running_o  (running),
      .match_o    (match),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] cnt;
      logic       run;
      logic       rdy;
      logic       mat;
      logic       irq;
      string      name;
   } exp_t;

   exp_t eq[$];
   int   mq[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      exp_t e;
      int   m;
      while (mq.size() > 0 && mq[0] < cyc) begin
         m = mq.pop_front();
         checks++;
         failures++;
         $display("FAIL missing_match cyc=%0d expected match at cyc=%0d", cyc, m);
      end
      if (match) begin
         checks++;
         if (mq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_match cyc=%0d count=%0d", cyc, count);
         end else begin
            m = mq.pop_front();
            if (m != cyc) begin
               failures++;
               $display("FAIL match_cycle actual=%0d required=%0d", cyc, m);
            end
         end
      end
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
         e = eq.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            failures++;
            $display("FAIL %s missed snapshot cyc=%0d", e.name, e.cyc);
         end else if ({count, running, ready, match, irq} !==
                      {e.cnt, e.run, e.rdy, e.mat, e.irq}) begin
            failures++;
            $display("FAIL %s cyc=%0d actual cnt=%0d run=%b rdy=%b mat=%b irq=%b required cnt=%0d run=%b rdy=%b mat=%b irq=%b",
                     e.name, cyc, count, running, ready, match, irq,
                     e.cnt, e.run, e.rdy, e.mat, e.irq);
         end
      end
   end

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] o, input logic [7:0] d, output int e);
      valid = 1'b1;
      op    = o;
      data  = d;
      tick1();
      valid = 1'b0;
      e     = cyc;
   endtask

   task automatic exp_at(input int c, input logic [7:0] cnt, input logic run,
                         input logic rdy, input logic mat, input logic ir,
                         input string nm);
      exp_t x;
      x.cyc = c; x.cnt = cnt; x.run = run; x.rdy = rdy;
      x.mat = mat; x.irq = ir; x.name = nm;
      eq.push_back(x);
   endtask

   initial begin
      int e;
      int e0;
      logic ir;

      repeat (3) tick1();
      exp_at(cyc, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "reset");
      reset_n = 1'b1;
      exp_at(cyc + 1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "post_reset");
      repeat (2) tick1();

      // one-shot, limit 5
      send(OP_LOAD, 8'd5, e0);
      exp_at(e0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "load5");
      periodic = 1'b0;
      send(OP_START, 8'd0, e);
      for (int k = 0; k <= 5; k++)
         exp_at(e + k, 8'(k), 1'b1, 1'b1, 1'b0, 1'b0, "oneshot_cnt");
      exp_at(e + 6, 8'd5, 1'b0, 1'b0, 1'b1, 1'b1, "oneshot_term");
      mq.push_back(e + 6);
      exp_at(e + 7, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1, "oneshot_idle");
      repeat (8) tick1();

      irq_clr = 1'b1;
      exp_at(cyc + 1, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, "irq_clr");
      tick1();
      irq_clr = 1'b0;
      send(OP_CLEAR, 8'd0, e);
      exp_at(e, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "clear");

      // periodic, limit 3, irq_clr collides with match at k=8, STOP at limit
      send(OP_LOAD, 8'd3, e0);
      periodic = 1'b1;
      send(OP_START, 8'd0, e);
      for (int k = 0; k <= 23; k++) begin
         ir = (k >= 4 && k <= 5) || (k >= 8);
         exp_at(e + k, 8'(k % 4), 1'b1, 1'b1, (k > 0 && k % 4 == 0), ir,
                "periodic");
      end
      for (int k = 4; k <= 20; k += 4) mq.push_back(e + k);
      exp_at(e + 24, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, "stop_at_limit");
      exp_at(e + 25, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, "stop_hold");
      for (int k = 1; k <= 24; k++) begin
         irq_clr = (k >= 6 && k <= 8);
         if (k == 24) begin
            valid = 1'b1;
            op    = OP_STOP;
         end
         tick1();
      end
      valid   = 1'b0;
      irq_clr = 1'b0;
      tick1();

      // limit 0 one-shot: match on the first tick
      send(OP_LOAD, 8'd0, e0);
      periodic = 1'b0;
      send(OP_START, 8'd0, e);
      exp_at(e, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, "lim0_start");
      exp_at(e + 1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, "lim0_term");
      mq.push_back(e + 1);
      exp_at(e + 2, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, "lim0_idle");
      repeat (3) tick1();

      // reset mid-run
      send(OP_LOAD, 8'd200, e0);
      send(OP_START, 8'd0, e);
      exp_at(e + 50, 8'd50, 1'b1, 1'b1, 1'b0, 1'b1, "run50");
      exp_at(e + 51, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "mid_reset");
      repeat (50) tick1();
      reset_n = 1'b0;
      tick1();
      reset_n = 1'b1;
      exp_at(cyc + 210, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset");
      repeat (211) tick1();

`ifdef COUNTER_CTRL_PRESCALE_EN
      prescale = 4'd2;
      send(OP_LOAD, 8'd1, e0);
      periodic = 1'b1;
      send(OP_START, 8'd0, e);
      for (int k = 0; k <= 18; k++)
         exp_at(e + k, 8'((k / 3) % 2), 1'b1, 1'b1, (k > 0 && k % 6 == 0),
                (k >= 6), "prescale");
      mq.push_back(e + 6);
      mq.push_back(e + 12);
      mq.push_back(e + 18);
      repeat (18) tick1();
      send(OP_STOP, 8'd0, e);
      exp_at(e, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, "prescale_stop");
      prescale = 4'd0;
`endif

      repeat (3) tick1();
      checks++;
      if (eq.size() != 0 || mq.size() != 0) begin
         failures++;
         $display("FAIL leftover actual=%0d/%0d required=0/0", eq.size(), mq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
